// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that merges NUM_REQ requesters into one FIFO write port in bursts.
// Optional saturating write_error counter, enabled by defining FIFO_ARB_ERR_CNT_EN.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                            wclk,
    input  logic                            wrst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            w_en,
    output logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            full,
    input  logic                            write_error,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic [7:0]                      err_cnt
);

    localparam int unsigned GID_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [GID_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic                  rr_found;
    logic [GID_W-1:0]      rr_idx;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  grant_we;

    // Requester index base+off, wrapped into 0..NUM_REQ-1.
    function automatic logic [GID_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return GID_W'(s);
    endfunction

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            grant_q <= GID_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    // Round-robin search starting one past the last grant.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = grant_q;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!rr_found && req_valid[wrap_idx(32'(grant_q), k)]) begin
                rr_found = 1'b1;
                rr_idx   = wrap_idx(32'(grant_q), k);
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GID_W'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next state and same-cycle write handshake; full freezes the grant in place.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        grant_we  = 1'b0;
        req_ready = '0;
        data_in   = '0;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_d = rr_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                data_in  = sel_data;
                grant_we = sel_valid & ~full;
                if (grant_we) begin
                    req_ready = NUM_REQ'(1) << grant_q;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
                if (!sel_valid || (grant_we && (cnt_q == CNT_W'(BURST_LEN - 1)))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign w_en     = grant_we;
    assign grant_id = grant_q;
    assign busy     = (state_q == GRANT);

`ifdef FIFO_ARB_ERR_CNT_EN
    logic [7:0] err_q;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            err_q <= '0;
        end else if (write_error && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    logic unused_write_error;
    assign unused_write_error = write_error;
    assign err_cnt            = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter: expected beats are queued per scenario and popped as w_en fires.
module tb_fifo_wr_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned BL   = 4;

`ifdef FIFO_ARB_ERR_CNT_EN
    localparam logic [7:0] ERR_AFTER_10  = 8'd10;
    localparam logic [7:0] ERR_AFTER_310 = 8'd255;
`else
    localparam logic [7:0] ERR_AFTER_10  = 8'd0;
    localparam logic [7:0] ERR_AFTER_310 = 8'd0;
`endif

    logic                wclk = 1'b0;
    logic                wrst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                w_en;
    logic [DW-1:0]       data_in;
    logic                full;
    logic                write_error;
    logic [1:0]          grant_id;
    logic                busy;
    logic [7:0]          err_cnt;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .w_en(w_en), .data_in(data_in), .full(full),
        .write_error(write_error), .grant_id(grant_id), .busy(busy), .err_cnt(err_cnt)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      b;
    int         n_total = 0;
    int         n_bad   = 0;
    logic [3:0] sent[NREQ];
    logic [3:0] exp_sent[NREQ];

    logic            obs_wen, obs_busy;
    logic [NREQ-1:0] obs_ready;
    logic [DW-1:0]   obs_data;
    logic [1:0]      obs_gid;
    logic [7:0]      obs_err;

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = {4'(i), sent[i]};
    endtask

    // Inputs are already applied; sample this cycle, then step past the next edge.
    task automatic cycle();
        @(negedge wclk);
        obs_wen = w_en; obs_busy = busy; obs_ready = req_ready;
        obs_data = data_in; obs_gid = grant_id; obs_err = err_cnt;
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) if (obs_ready[i]) sent[i] = sent[i] + 4'd1;
        drive_data();
    endtask

    task automatic push_beats(input int id, input int n);
        beat_t nb;
        for (int j = 0; j < n; j++) begin
            nb.id   = 2'(id);
            nb.data = {4'(id), exp_sent[id]};
            exp_q.push_back(nb);
            exp_sent[id] = exp_sent[id] + 4'd1;
        end
    endtask

    task automatic do_reset();
        wrst_n = 1'b0; req_valid = '0; full = 1'b0; write_error = 1'b0;
        cycle();
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) wrst_n = 1'b1;
            cycle();
            n_total++;
            if (obs_wen !== 1'b0 || obs_ready !== 4'b0 || obs_data !== 8'h00 || obs_busy !== 1'b0
                || obs_gid !== 2'd3 || obs_err !== 8'd0) begin
                n_bad++;
                $display("FAIL reset c=%0d got wen=%b rdy=%b data=%h busy=%b gid=%0d err=%0d exp 0,0,00,0,3,0",
                         c, obs_wen, obs_ready, obs_data, obs_busy, obs_gid, obs_err);
            end
        end
    endtask

    task automatic test_single();
        logic [0:9] pat;
        pat = 10'b0111101111;
        do_reset();
        push_beats(0, 8);
        for (int c = 0; c < 10; c++) begin
            req_valid = 4'b0001;
            cycle();
            n_total++;
            if (obs_wen !== pat[c]) begin
                n_bad++; $display("FAIL single_wen c=%0d got=%b exp=%b", c, obs_wen, pat[c]);
            end
            if (obs_wen) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL single_extra_beat c=%0d data=%h", c, obs_data);
                end else begin
                    b = exp_q.pop_front();
                    if (obs_gid !== b.id || obs_data !== b.data || obs_ready !== (4'b0001 << b.id)) begin
                        n_bad++;
                        $display("FAIL single_beat c=%0d got gid=%0d data=%h rdy=%b exp gid=%0d data=%h",
                                 c, obs_gid, obs_data, obs_ready, b.id, b.data);
                    end
                end
            end else begin
                n_total++;
                if (obs_ready !== 4'b0 || obs_busy !== 1'b0 || obs_data !== 8'h00) begin
                    n_bad++; $display("FAIL single_idle c=%0d got rdy=%b busy=%b data=%h exp 0,0,00",
                                      c, obs_ready, obs_busy, obs_data);
                end
            end
        end
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL single_missing got=%0d left exp=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_round_robin();
        logic exp_we;
        do_reset();
        for (int g = 0; g < 5; g++) push_beats(g % 4, 4);
        for (int c = 0; c < 25; c++) begin
            req_valid = 4'b1111;
            exp_we = (c % 5) != 0;
            cycle();
            n_total++;
            if (obs_wen !== exp_we) begin
                n_bad++; $display("FAIL rr_wen c=%0d got=%b exp=%b", c, obs_wen, exp_we);
            end
            if (obs_wen) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rr_extra_beat c=%0d data=%h", c, obs_data);
                end else begin
                    b = exp_q.pop_front();
                    if (obs_gid !== b.id || obs_data !== b.data || obs_ready !== (4'b0001 << b.id)) begin
                        n_bad++;
                        $display("FAIL rr_beat c=%0d got gid=%0d data=%h rdy=%b exp gid=%0d data=%h",
                                 c, obs_gid, obs_data, obs_ready, b.id, b.data);
                    end
                end
            end
        end
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL rr_missing got=%0d left exp=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_full_stall();
        logic [0:8] pat;
        pat = 9'b011000110;
        do_reset();
        push_beats(2, 4);
        for (int c = 0; c < 9; c++) begin
            req_valid = 4'b1100;
            full = (c >= 3 && c <= 5);
            cycle();
            n_total++;
            if (obs_wen !== pat[c]) begin
                n_bad++; $display("FAIL stall_wen c=%0d got=%b exp=%b", c, obs_wen, pat[c]);
            end
            if (full) begin
                n_total++;
                if (obs_gid !== 2'd2 || obs_busy !== 1'b1 || obs_ready !== 4'b0) begin
                    n_bad++; $display("FAIL stall_hold c=%0d got gid=%0d busy=%b rdy=%b exp 2,1,0000",
                                      c, obs_gid, obs_busy, obs_ready);
                end
            end
            if (obs_wen) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL stall_extra_beat c=%0d data=%h", c, obs_data);
                end else begin
                    b = exp_q.pop_front();
                    if (obs_gid !== b.id || obs_data !== b.data || obs_ready !== (4'b0001 << b.id)) begin
                        n_bad++;
                        $display("FAIL stall_beat c=%0d got gid=%0d data=%h rdy=%b exp gid=%0d data=%h",
                                 c, obs_gid, obs_data, obs_ready, b.id, b.data);
                    end
                end
            end
        end
        full = 1'b0;
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL stall_missing got=%0d left exp=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_drop();
        logic [0:9] pat;
        pat = 10'b0110011110;
        do_reset();
        push_beats(2, 2);
        push_beats(3, 4);
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 3) ? 4'b0100 : 4'b1000;
            cycle();
            n_total++;
            if (obs_wen !== pat[c]) begin
                n_bad++; $display("FAIL drop_wen c=%0d got=%b exp=%b", c, obs_wen, pat[c]);
            end
            if (c == 3 || c == 4) begin
                n_total++;
                if (obs_busy !== (c == 3)) begin
                    n_bad++; $display("FAIL drop_busy c=%0d got=%b exp=%b", c, obs_busy, c == 3);
                end
            end
            if (obs_wen) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL drop_extra_beat c=%0d data=%h", c, obs_data);
                end else begin
                    b = exp_q.pop_front();
                    if (obs_gid !== b.id || obs_data !== b.data || obs_ready !== (4'b0001 << b.id)) begin
                        n_bad++;
                        $display("FAIL drop_beat c=%0d got gid=%0d data=%h rdy=%b exp gid=%0d data=%h",
                                 c, obs_gid, obs_data, obs_ready, b.id, b.data);
                    end
                end
            end
        end
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL drop_missing got=%0d left exp=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_drop_while_full();
        logic [0:4] pat;
        pat = 5'b01000;
        do_reset();
        push_beats(1, 1);
        for (int c = 0; c < 5; c++) begin
            req_valid = (c < 3) ? 4'b0010 : 4'b0000;
            full = (c == 2 || c == 3);
            cycle();
            n_total++;
            if (obs_wen !== pat[c]) begin
                n_bad++; $display("FAIL dropfull_wen c=%0d got=%b exp=%b", c, obs_wen, pat[c]);
            end
            if (c >= 3) begin
                n_total++;
                if (obs_busy !== (c == 3) || obs_gid !== 2'd1) begin
                    n_bad++; $display("FAIL dropfull_state c=%0d got busy=%b gid=%0d exp busy=%b gid=1",
                                      c, obs_busy, obs_gid, c == 3);
                end
            end
            if (obs_wen) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL dropfull_extra_beat c=%0d data=%h", c, obs_data);
                end else begin
                    b = exp_q.pop_front();
                    if (obs_gid !== b.id || obs_data !== b.data || obs_ready !== (4'b0001 << b.id)) begin
                        n_bad++;
                        $display("FAIL dropfull_beat c=%0d got gid=%0d data=%h exp gid=%0d data=%h",
                                 c, obs_gid, obs_data, b.id, b.data);
                    end
                end
            end
        end
        full = 1'b0;
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL dropfull_missing got=%0d left exp=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        logic [0:9] pat;
        pat = 10'b0111011110;
        do_reset();
        push_beats(0, 3);
        push_beats(0, 4);
        for (int c = 0; c < 10; c++) begin
            req_valid = 4'b0011;
            wrst_n = (c != 3);
            cycle();
            n_total++;
            if (obs_wen !== pat[c]) begin
                n_bad++; $display("FAIL rstmid_wen c=%0d got=%b exp=%b", c, obs_wen, pat[c]);
            end
            if (c == 4) begin
                n_total++;
                if (obs_gid !== 2'd3 || obs_busy !== 1'b0 || obs_data !== 8'h00) begin
                    n_bad++; $display("FAIL rstmid_state got gid=%0d busy=%b data=%h exp 3,0,00",
                                      obs_gid, obs_busy, obs_data);
                end
            end
            if (obs_wen) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rstmid_extra_beat c=%0d data=%h", c, obs_data);
                end else begin
                    b = exp_q.pop_front();
                    if (obs_gid !== b.id || obs_data !== b.data || obs_ready !== (4'b0001 << b.id)) begin
                        n_bad++;
                        $display("FAIL rstmid_beat c=%0d got gid=%0d data=%h rdy=%b exp gid=%0d data=%h",
                                 c, obs_gid, obs_data, obs_ready, b.id, b.data);
                    end
                end
            end
        end
        wrst_n = 1'b1;
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL rstmid_missing got=%0d left exp=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_err_cnt();
        do_reset();
        write_error = 1'b1;
        for (int c = 0; c < 10; c++) cycle();
        write_error = 1'b0;
        cycle();
        n_total++;
        if (obs_err !== ERR_AFTER_10) begin
            n_bad++; $display("FAIL err_10 got=%0d exp=%0d", obs_err, ERR_AFTER_10);
        end
        write_error = 1'b1;
        for (int c = 0; c < 300; c++) cycle();
        write_error = 1'b0;
        cycle();
        n_total++;
        if (obs_err !== ERR_AFTER_310) begin
            n_bad++; $display("FAIL err_sat got=%0d exp=%0d", obs_err, ERR_AFTER_310);
        end
        do_reset();
        cycle();
        n_total++;
        if (obs_err !== 8'd0) begin
            n_bad++; $display("FAIL err_reset got=%0d exp=0", obs_err);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        wrst_n = 1'b0; req_valid = '0; full = 1'b0; write_error = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            sent[i]     = 4'd0;
            exp_sent[i] = 4'd0;
        end
        drive_data();
        @(posedge wclk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_drop();
        test_drop_while_full();
        test_reset_mid_burst();
        test_err_cnt();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of write requesters, range 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: FIFO data width.
REQ-003 SHALL have parameter BURST_LEN, default 4: maximum beats per grant, range 1..15.
REQ-004 SHALL have one clock and a synchronous, active-low reset, on ports named wclk and wrst_n.
REQ-005 wclk  in  1  write-domain clock; all state updates on its rising edge.
REQ-006 wrst_n  in  1  synchronous active-low reset.
REQ-007 req_valid  in  NUM_REQ  requester i has a beat to write.
REQ-008 req_data  in  NUM_REQ*DATA_WIDTH  requester i's data at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_ready  out  NUM_REQ  beat from requester i accepted this cycle.
REQ-010 w_en  out  1  FIFO write enable.
REQ-011 data_in  out  DATA_WIDTH  FIFO write data.
REQ-012 full  in  1  FIFO full flag.
REQ-013 write_error  in  1  FIFO overflow pulse.
REQ-014 grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
REQ-015 busy  out  1  high while the FSM is in GRANT.
REQ-016 err_cnt  out  8  saturating count of write_error pulses.

Function
REQ-017 SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-018 IDLE: if any req_valid is high, SHALL load grant_id with the first valid index searched round-robin from grant_id+1 (wrapping NUM_REQ-1 -> 0), clear the beat counter and go to GRANT next cycle; otherwise SHALL stay in IDLE.
REQ-019 GRANT: w_en SHALL equal req_valid[grant_id] AND NOT full, combinationally in the same cycle.
REQ-020 data_in SHALL equal req_data for grant_id whenever in GRANT, and SHALL be zero in IDLE.
REQ-021 req_ready[grant_id] SHALL equal w_en; every other req_ready bit SHALL be 0.
REQ-022 Beat counter SHALL increment on each cycle with w_en high and SHALL hold while full.
REQ-023 GRANT -> IDLE when w_en is high and the beat counter equals BURST_LEN-1, or when req_valid[grant_id] is low.
REQ-024 With full high, the FSM SHALL stay in GRANT, w_en SHALL be 0, and the grant SHALL NOT move to another requester.
REQ-025 Every GRANT -> IDLE transition SHALL insert exactly one idle cycle; peak throughput is BURST_LEN beats per BURST_LEN+1 cycles.
REQ-026 Lowering req_valid while full is high SHALL end the grant with no beat written.
REQ-027 w_en SHALL never be high while full is high.

Reset
REQ-028 When wrst_n is low at a wclk edge: FSM = IDLE, grant_id = NUM_REQ-1 (so requester 0 wins first), beat counter = 0, err_cnt = 0.
REQ-029 During and after reset, until the first grant: w_en = 0, req_ready = 0, data_in = 0, busy = 0.
REQ-030 Reset asserted mid-burst SHALL abort the burst at that edge; no further w_en SHALL be issued.

Configuration
REQ-031 Macro FIFO_ARB_ERR_CNT_EN SHALL control err_cnt.
REQ-032 With FIFO_ARB_ERR_CNT_EN defined: err_cnt SHALL increment by 1 on each cycle with write_error high and saturate at 255.
REQ-033 Without FIFO_ARB_ERR_CNT_EN: err_cnt SHALL be tied to 0, write_error SHALL be ignored, and no counter register SHALL be built.

Verification
REQ-034 After reset, req_valid=4'b0001 held with full=0 -> one idle cycle, then w_en high 4 cycles (beats 0..3), one idle cycle, then the next 4-beat grant to requester 0.
REQ-035 req_valid=4'b1111 held -> grants in order 0,1,2,3,0, each 4 beats, with one idle cycle between grants.
REQ-036 Requester 2 granted and full raised for 3 cycles after beat 1 -> w_en=0 for those 3 cycles, grant_id stays 2, beats 2..3 complete after full falls.
REQ-037 req_valid=4'b0100, then bit 2 dropped after 2 beats -> grant ends after 2 beats; requester 3 (valid) is next.
REQ-038 wrst_n low for one cycle during beat 2 of a burst -> w_en=0 from that edge; first subsequent grant goes to requester 0.
REQ-039 FIFO_ARB_ERR_CNT_EN defined, 300 write_error pulses -> err_cnt=255; macro undefined -> err_cnt=0.
